// File: rtl/btn_pulse_cond_if.sv
// Button/pulse bundle between the front-end conditioner and the datapath.
// The conditioner is master; the datapath (or a bench) is slave.
interface btn_pulse_cond_if;
  logic [7:0] btn_raw;
  logic       Pulse;
  logic       Reset;
  logic       Timeset;
  logic       Alarmset;
  logic       Minadv;
  logic       Hrsadv;
  logic       Dayadv;
  logic       Dateadv;
  logic       Monthadv;
  logic       Alarmon;

  modport master (
    input  btn_raw,
    output Pulse, Reset,
    output Timeset, Alarmset,
    output Minadv, Hrsadv, Dayadv,
    output Dateadv, Monthadv, Alarmon
  );

  modport slave (
    output btn_raw,
    input  Pulse, Reset,
    input  Timeset, Alarmset,
    input  Minadv, Hrsadv, Dayadv,
    input  Dateadv, Monthadv, Alarmon
  );
endinterface

// File: rtl/btn_pulse_cond.sv
// Clock/calendar front end: 1 Hz Pulse divider, reset synchronizer,
// button synchronize/debounce and Pulse-aligned re-timing of button levels.
module btn_pulse_cond #(
  parameter int DIV       = 50_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  btn_pulse_cond_if.master bus
);
  localparam int CW   = $clog2(DIV);
  localparam int HALF = DIV / 2;
  localparam int RCW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_MAX = RCW'(DB_CYCLES - 1);

  logic [1:0]          rs_q;
  logic                reset_w;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pulse_q, pulse_d;
  logic                load;
  logic [7:0]          s1_q, s2_q;
  logic [7:0]          db_q, db_d;
  logic [7:0][RCW-1:0] rc_q, rc_d;
  logic [7:0]          stage_q, stage_d;
  logic                gate;

  // Reset asserts asynchronously, releases on the 2nd edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rs_q <= 2'b11;
    else      rs_q <= {rs_q[0], 1'b0};
  end

  assign reset_w = rs_q[1];

  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (!reset_w) begin
      if (cnt_q != CW'(DIV - 1)) cnt_d = cnt_q + CW'(1);
      pulse_d = (cnt_q >= CW'(HALF));
    end
  end

  // Outputs are re-timed onto the Pulse falling edge.
  assign load = pulse_q & ~pulse_d;

  always_comb begin
    db_d    = db_q;
    rc_d    = '0;
    stage_d = load ? db_q : stage_q;
    for (int i = 0; i < 8; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (rc_q[i] == RC_MAX) db_d[i] = s2_q[i];
        else                   rc_d[i] = rc_q[i] + RCW'(1);
      end
    end
    if (reset_w) begin
      db_d    = '0;
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      rc_q    <= '0;
      stage_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      s1_q    <= reset_w ? 8'h00 : bus.btn_raw;
      s2_q    <= reset_w ? 8'h00 : s1_q;
      db_q    <= db_d;
      rc_q    <= rc_d;
      stage_q <= stage_d;
    end
  end

  // Advance buttons only act with exactly one set-button held.
  assign gate = stage_q[0] ^ stage_q[1];

  assign bus.Pulse    = pulse_q;
  assign bus.Reset    = reset_w;
  assign bus.Timeset  = stage_q[0];
  assign bus.Alarmset = stage_q[1];
  assign bus.Minadv   = stage_q[2] & gate;
  assign bus.Hrsadv   = stage_q[3] & gate;
  assign bus.Dayadv   = stage_q[4] & gate;
  assign bus.Dateadv  = stage_q[5] & gate;
  assign bus.Monthadv = stage_q[6] & gate;
  assign bus.Alarmon  = stage_q[7];
endmodule
